disp_arbiter: RTL

Round-robin scheduler that shares the board's single 8-digit seven-segment display between several 32-bit value sources (PC, register probe, memory-mapped display port, debug counter).

- Each source raises a request and presents a 32-bit word.
- The arbiter grants one source at a time and drives the granted word onto `x`, the 32-bit value bus feeding the display multiplexer.
- Each owner keeps the display for a minimum dwell time before another source can take it.
- The block sits between the CPU/debug logic and the display multiplexer.

---
 rtl/disp_arbiter_if.sv | 37 +++
 rtl/disp_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/disp_arbiter_if.sv
// rtl/disp_arbiter_if.sv - request/data/grant bundle between display sources and the arbiter
// Ports (signals):
//   req   [NREQ]     request bit per source
//   data  [32*NREQ]  source i word at data[32*i +: 32]
//   grant [NREQ]     one-cycle one-hot pulse on ownership change
//   owner [3]        current or last owner index
//   busy             high while an owner holds the display
//   x     [32]       registered display word
// master: source/display side, slave: arbiter side.
interface disp_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   data;
    logic [NREQ-1:0]      grant;
    logic [2:0]           owner;
    logic                 busy;
    logic [31:0]          x;

    modport master (
        output req,
        output data,
        input  grant,
        input  owner,
        input  busy,
        input  x
    );

    modport slave (
        input  req,
        input  data,
        output grant,
        output owner,
        output busy,
        output x
    );
endinterface

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin owner arbiter for the shared seven-segment display
// Ports:
//   clk  system clock, rising edge
//   clr  synchronous active-high reset
//   bus  disp_arbiter_if slave: req/data in, grant/owner/busy/x out (all registered)
module disp_arbiter #(
    parameter int NREQ  = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic          clk,
    input  logic          clr,
    disp_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      owner_q, owner_d;
    logic [31:0]     x_q,     x_d;

    logic            any_found, oth_found;
    logic [2:0]      any_idx,   oth_idx;
    logic            req_own;

    function automatic int wrap_idx(input int v);
        return (v >= NREQ) ? v - NREQ : v;
    endfunction

    function automatic logic [31:0] word_of(input logic [32*NREQ-1:0] d, input logic [2:0] sel);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) w = d[32*i +: 32];
        end
        return w;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] sel);
        logic [NREQ-1:0] g;
        g = '0;
        for (int i = 0; i < NREQ; i++) begin
            g[i] = (sel == 3'(i));
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [2:0] sel);
        return PW'(wrap_idx(int'(sel) + 1));
    endfunction

    // Two round-robin searches from ptr: one over all requesters (IDLE grant)
    // and one excluding the owner (dwell-expiry handover). Slot k in search
    // order maps to source (ptr + k) mod NREQ.
    always_comb begin
        any_found = 1'b0;
        any_idx   = '0;
        oth_found = 1'b0;
        oth_idx   = '0;
        req_own   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == wrap_idx(int'(ptr_q) + k)) begin
                    if (!any_found && bus.req[i]) begin
                        any_found = 1'b1;
                        any_idx   = 3'(i);
                    end
                    if (!oth_found && bus.req[i] && (owner_q != 3'(i))) begin
                        oth_found = 1'b1;
                        oth_idx   = 3'(i);
                    end
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) req_own = bus.req[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        owner_d = owner_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: begin
                if (any_found) begin
                    grant_d = onehot(any_idx);
                    owner_d = any_idx;
                    x_d     = word_of(bus.data, any_idx);
                    ptr_d   = ptr_after(any_idx);
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (oth_found) begin
                        grant_d = onehot(oth_idx);
                        owner_d = oth_idx;
                        x_d     = word_of(bus.data, oth_idx);
                        ptr_d   = ptr_after(oth_idx);
                    end else if (req_own) begin
                        // Owner keeps the display silently; live update continues.
                        x_d = word_of(bus.data, owner_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (req_own) x_d = word_of(bus.data, owner_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            owner_q <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            x_q     <= x_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == S_HOLD);
    assign bus.x     = x_q;
endmodule
